// File: rtl/accum_ctrl_fsm.sv
// Multi-cycle control sequencer for a 16-bit accumulator datapath.
// It fetches, decodes and executes one instruction at a time. IR[15:8] holds
// the address and IR[7:0] holds the opcode. It also drives the datapath load
// strobes, the mux selects, the ALU op and the memory write enable.
// The module has no valid/ready handshake. Start is a level: Start = 1 in IDLE
// begins fetching. Only a low Rst returns the sequencer to IDLE.
// dbg_state exposes the state register so checkers can follow the FSM.
module accum_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [1:0]  ALU_ADD  = 2'b00,
  parameter logic [1:0]  ALU_SUB  = 2'b01,
  parameter logic [1:0]  ALU_AND  = 2'b10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  opcode,
  input  logic        Zflag,
  output logic        loadPC,
  output logic        loadIR,
  output logic        loadACC,
  output logic        loadMDR,
  output logic        loadMAR,
  output logic        muxPC,
  output logic        muxMAR,
  output logic        muxACC,
  output logic [1:0]  opALU,
  output logic        MemWE,
  output logic        Halted,
  output logic [15:0] InstrCnt,
  output logic [3:0]  dbg_state
);

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_JZ    = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'h08;

  // The wait counter starts at MEM_WAIT-1 so that a wait state lasts exactly MEM_WAIT cycles.
  localparam int unsigned WAIT_M1   = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
  localparam logic [3:0]  WAIT_INIT = WAIT_M1[3:0];

  // The state encoding is fixed because dbg_state shows it to observers.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_WAIT  = 4'd2,
    S_F_MEM   = 4'd3,
    S_F_IR    = 4'd4,
    S_DECODE  = 4'd5,
    S_E_ADDR  = 4'd6,
    S_E_WAIT  = 4'd7,
    S_E_MEM   = 4'd8,
    S_E_ACC   = 4'd9,
    S_E_STORE = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] cnt_q, cnt_d;

  // Register the state, the wait counter, the latched opcode and the instruction count.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      op_q    <= 8'h00;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Compute the next state. The opcode is latched in DECODE so the E_* states need no valid IR.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_F_ADDR;
      S_F_ADDR: begin
        if (MEM_WAIT > 0) begin
          state_d = S_F_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_F_MEM;
        end
      end
      S_F_WAIT: begin
        if (wait_q == 4'd0) state_d = S_F_MEM;
        else                wait_d  = wait_q - 4'd1;
      end
      S_F_MEM:  state_d = S_F_IR;
      S_F_IR:   state_d = S_DECODE;
      S_DECODE: begin
        cnt_d = cnt_q + 16'd1;
        op_d  = opcode;
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: state_d = S_E_ADDR;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_F_ADDR;
        endcase
      end
      S_E_ADDR: begin
        if (op_q == OP_STORE) begin
          state_d = S_E_STORE;
        end else if (MEM_WAIT > 0) begin
          state_d = S_E_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_E_MEM;
        end
      end
      S_E_WAIT: begin
        if (wait_q == 4'd0) state_d = S_E_MEM;
        else                wait_d  = wait_q - 4'd1;
      end
      S_E_MEM:   state_d = S_E_ACC;
      S_E_ACC:   state_d = S_F_ADDR;
      S_E_STORE: state_d = S_F_ADDR;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Decode the outputs from the state. In DECODE the PC strobes also depend on opcode and Zflag.
  always_comb begin
    loadPC  = 1'b0;
    loadIR  = 1'b0;
    loadACC = 1'b0;
    loadMDR = 1'b0;
    loadMAR = 1'b0;
    muxPC   = 1'b0;
    muxMAR  = 1'b0;
    muxACC  = 1'b0;
    opALU   = ALU_ADD;
    MemWE   = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      S_F_ADDR: begin
        loadMAR = 1'b1;
        muxMAR  = 1'b1;
      end
      S_F_MEM: begin
        loadMDR = 1'b1;
        loadPC  = 1'b1;
      end
      S_F_IR:   loadIR = 1'b1;
      S_DECODE: begin
        if ((opcode == OP_JMP) || ((opcode == OP_JZ) && Zflag)) begin
          loadPC = 1'b1;
          muxPC  = 1'b1;
        end
      end
      S_E_ADDR: loadMAR = 1'b1;
      S_E_MEM, S_E_ACC: begin
        if (op_q == OP_SUB)      opALU = ALU_SUB;
        else if (op_q == OP_AND) opALU = ALU_AND;
        if (state_q == S_E_MEM) begin
          loadMDR = 1'b1;
        end else begin
          loadACC = 1'b1;
          muxACC  = (op_q == OP_LOAD);
        end
      end
      S_E_STORE: MemWE  = 1'b1;
      S_HALT:    Halted = 1'b1;
      default: ;
    endcase
  end

  assign InstrCnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_accum_ctrl_fsm.sv
// Directed testbench for accum_ctrl_fsm. dut runs with MEM_WAIT = 0 and drives
// a small behavioural datapath with memory. w_dut runs with MEM_WAIT = 3 and
// sees a constant LOAD opcode so its strobe timing can be checked.
module tb_accum_ctrl_fsm;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_F_ADDR = 4'd1, ST_F_WAIT = 4'd2,
                         ST_DECODE = 4'd5, ST_E_MEM = 4'd8, ST_E_ACC = 4'd9,
                         ST_HALT = 4'd11;

  // clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst = 1'b0, Start = 1'b0, start_w = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // dut (MEM_WAIT = 0) signals
  logic        load_pc, load_ir, load_acc, load_mdr, load_mar;
  logic        mux_pc, mux_mar, mux_acc, mem_we, halted;
  logic [1:0]  op_alu;
  logic [15:0] instr_cnt;
  logic [3:0]  state;
  logic [7:0]  opcode;
  logic        zflag;
  logic [6:0]  strb;
  assign strb = {load_pc, load_ir, load_acc, load_mdr, load_mar, mem_we, halted};

  // w_dut (MEM_WAIT = 3) signals
  logic        w_load_pc, w_load_ir, w_load_acc, w_load_mdr, w_load_mar;
  logic        w_mux_pc, w_mux_mar, w_mux_acc, w_mem_we, w_halted;
  logic [1:0]  w_op_alu;
  logic [15:0] w_instr_cnt;
  logic [3:0]  w_state;
  logic [7:0]  w_opcode = 8'h01;
  logic        w_zflag = 1'b0;
  logic [6:0]  w_strb;
  assign w_strb = {w_load_pc, w_load_ir, w_load_acc, w_load_mdr, w_load_mar, w_mem_we, w_halted};

  accum_ctrl_fsm #(.MEM_WAIT(0)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .opcode(opcode), .Zflag(zflag),
    .loadPC(load_pc), .loadIR(load_ir), .loadACC(load_acc), .loadMDR(load_mdr),
    .loadMAR(load_mar), .muxPC(mux_pc), .muxMAR(mux_mar), .muxACC(mux_acc),
    .opALU(op_alu), .MemWE(mem_we), .Halted(halted), .InstrCnt(instr_cnt),
    .dbg_state(state)
  );

  accum_ctrl_fsm #(.MEM_WAIT(3)) w_dut (
    .Clk(Clk), .Rst(Rst), .Start(start_w), .opcode(w_opcode), .Zflag(w_zflag),
    .loadPC(w_load_pc), .loadIR(w_load_ir), .loadACC(w_load_acc), .loadMDR(w_load_mdr),
    .loadMAR(w_load_mar), .muxPC(w_mux_pc), .muxMAR(w_mux_mar), .muxACC(w_mux_acc),
    .opALU(w_op_alu), .MemWE(w_mem_we), .Halted(w_halted), .InstrCnt(w_instr_cnt),
    .dbg_state(w_state)
  );

  // behavioural datapath for dut
  logic [15:0] mem [256];
  logic [7:0]  pc, mar;
  logic [15:0] ir, acc, mdr, alu_out;
  logic [15:0] acc_rst_val = 16'h0000;

  always_comb begin
    case (op_alu)
      2'b00:   alu_out = acc + mdr;
      2'b01:   alu_out = acc - mdr;
      2'b10:   alu_out = acc & mdr;
      default: alu_out = acc;
    endcase
    opcode = ir[7:0];
    zflag  = (acc == 16'h0000);
  end

  always @(posedge Clk) begin
    if (!Rst) begin
      pc <= 8'h00; mar <= 8'h00; ir <= 16'h0000; mdr <= 16'h0000; acc <= acc_rst_val;
    end else begin
      if (load_mar) mar <= mux_mar ? pc : ir[15:8];
      if (load_pc)  pc  <= mux_pc ? ir[15:8] : pc + 8'd1;
      if (load_mdr) mdr <= mem[mar];
      if (load_ir)  ir  <= mdr;
      if (load_acc) acc <= mux_acc ? mdr : alu_out;
      if (mem_we)   mem[mar] <= acc;
    end
  end

  // Holds reset for 3 cycles and clears memory. Rst stays low on return.
  task automatic apply_reset(input logic [15:0] acc_init);
    @(negedge Clk);
    Rst = 1'b0; Start = 1'b0; start_w = 1'b0; acc_rst_val = acc_init;
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    apply_reset(16'h0000);
    n_cmp++; if (strb !== 7'd0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000000", strb); end
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    n_cmp++; if (instr_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_instrcnt: got %0d want 0", instr_cnt); end
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL idle_hold_state: got %0d want %0d", state, ST_IDLE); end
    n_cmp++; if (strb !== 7'd0) begin n_bad++; $display("FAIL idle_hold_strobes: got %b want 0000000", strb); end
    Start = 1'b1;
    @(negedge Clk);
    n_cmp++; if ({load_mar, mux_mar} !== 2'b11) begin n_bad++; $display("FAIL start_fetch: got loadMAR/muxMAR=%b want 11", {load_mar, mux_mar}); end
  endtask

  task automatic test_load_add();
    apply_reset(16'h0000);
    mem[0] = 16'h1001; mem[1] = 16'h1103; mem[2] = 16'h0008;
    mem[8'h10] = 16'd5; mem[8'h11] = 16'd7;
    Rst = 1'b1; Start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge Clk);
      if (c == 7) begin
        n_cmp++; if ({load_acc, mux_acc} !== 2'b11) begin n_bad++; $display("FAIL load_accsel: got loadACC/muxACC=%b want 11", {load_acc, mux_acc}); end
      end
      if (c == 8) begin
        n_cmp++; if (acc !== 16'd5) begin n_bad++; $display("FAIL load_acc: got %0d want 5", acc); end
      end
      if (c == 14) begin
        n_cmp++; if ({load_acc, mux_acc, op_alu} !== 4'b1000) begin n_bad++; $display("FAIL add_accsel: got loadACC/muxACC/opALU=%b want 1000", {load_acc, mux_acc, op_alu}); end
      end
      if (c == 15) begin
        n_cmp++; if (acc !== 16'd12) begin n_bad++; $display("FAIL add_acc: got %0d want 12", acc); end
        n_cmp++; if (state !== ST_F_ADDR) begin n_bad++; $display("FAIL add_len: got state %0d want %0d", state, ST_F_ADDR); end
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL load_add_halt: got %b want 1", halted); end
    n_cmp++; if (instr_cnt !== 16'd3) begin n_bad++; $display("FAIL load_add_cnt: got %0d want 3", instr_cnt); end
  endtask

  task automatic test_store_jz(input logic [15:0] acc_init, input logic exp_taken, input logic [7:0] exp_pc);
    int we_cnt = 0, we_cyc = 0;
    logic [7:0] we_addr = 8'h00;
    apply_reset(acc_init);
    mem[0] = 16'h2002; mem[1] = 16'h0507; mem[5] = 16'h0008; mem[8'h20] = 16'hBEEF;
    Rst = 1'b1; Start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clk);
      if (mem_we) begin we_cnt++; we_cyc = c; we_addr = mar; end
      if (c == 10) begin
        n_cmp++; if ({load_pc, mux_pc} !== {exp_taken, exp_taken}) begin n_bad++; $display("FAIL jz_decode: got loadPC/muxPC=%b want %b%b", {load_pc, mux_pc}, exp_taken, exp_taken); end
      end
    end
    n_cmp++; if (we_cnt !== 1) begin n_bad++; $display("FAIL store_pulses: got %0d want 1", we_cnt); end
    n_cmp++; if (we_cyc !== 6) begin n_bad++; $display("FAIL store_cycle: got %0d want 6", we_cyc); end
    n_cmp++; if (we_addr !== 8'h20) begin n_bad++; $display("FAIL store_addr: got %h want 20", we_addr); end
    n_cmp++; if (mem[8'h20] !== acc_init) begin n_bad++; $display("FAIL store_data: got %h want %h", mem[8'h20], acc_init); end
    n_cmp++; if (pc !== exp_pc) begin n_bad++; $display("FAIL jz_pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_wait_states();
    logic [6:0] exp_s;
    apply_reset(16'h0000);
    Rst = 1'b1; start_w = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      case (c)
        1, 8, 14: exp_s = 7'b0000100;
        5:        exp_s = 7'b1001000;
        6:        exp_s = 7'b0100000;
        12:       exp_s = 7'b0001000;
        13:       exp_s = 7'b0010000;
        default:  exp_s = 7'b0000000;
      endcase
      n_cmp++; if (w_strb !== exp_s) begin n_bad++; $display("FAIL wait_strobes c%0d: got %b want %b", c, w_strb, exp_s); end
      if (c == 2) begin
        n_cmp++; if (w_state !== ST_F_WAIT) begin n_bad++; $display("FAIL wait_state: got %0d want %0d", w_state, ST_F_WAIT); end
      end
      if (c == 8) begin
        n_cmp++; if (w_mux_mar !== 1'b0) begin n_bad++; $display("FAIL wait_exec_mar: got %b want 0", w_mux_mar); end
      end
      if (c == 13) begin
        n_cmp++; if (w_mux_acc !== 1'b1) begin n_bad++; $display("FAIL wait_muxacc: got %b want 1", w_mux_acc); end
      end
    end
  endtask

  task automatic test_halt_nop();
    apply_reset(16'h0000);
    mem[0] = 16'h00FF; mem[1] = 16'h0008;
    Rst = 1'b1; Start = 1'b1;
    for (int c = 1; c <= 58; c++) begin
      @(negedge Clk);
      if (c == 8) begin
        n_cmp++; if ({state, halted} !== {ST_DECODE, 1'b0}) begin n_bad++; $display("FAIL nop_len: got state %0d halted %b want %0d 0", state, halted, ST_DECODE); end
      end
      if (c >= 9) begin
        n_cmp++; if (strb !== 7'b0000001) begin n_bad++; $display("FAIL halt_hold c%0d: got %b want 0000001", c, strb); end
      end
    end
    n_cmp++; if (state !== ST_HALT) begin n_bad++; $display("FAIL halt_state: got %0d want %0d", state, ST_HALT); end
    n_cmp++; if (instr_cnt !== 16'd2) begin n_bad++; $display("FAIL halt_cnt: got %0d want 2", instr_cnt); end
  endtask

  task automatic test_reset_mid();
    int we_seen = 0, not_idle = 0;
    apply_reset(16'h0000);
    mem[0] = 16'h1001; mem[8'h10] = 16'd5;
    Rst = 1'b1; Start = 1'b1;
    repeat (6) @(negedge Clk);
    n_cmp++; if ({state, load_mdr} !== {ST_E_MEM, 1'b1}) begin n_bad++; $display("FAIL mid_pre: got state %0d loadMDR %b want %0d 1", state, load_mdr, ST_E_MEM); end
    Rst = 1'b0; Start = 1'b0;
    @(negedge Clk);
    n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL mid_state: got %0d want %0d", state, ST_IDLE); end
    n_cmp++; if (strb !== 7'd0) begin n_bad++; $display("FAIL mid_strobes: got %b want 0000000", strb); end
    n_cmp++; if (instr_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d want 0", instr_cnt); end
    @(negedge Clk);
    Rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (mem_we) we_seen++;
      if (state !== ST_IDLE) not_idle++;
    end
    n_cmp++; if (we_seen !== 0) begin n_bad++; $display("FAIL mid_memwe: got %0d pulses want 0", we_seen); end
    n_cmp++; if (not_idle !== 0) begin n_bad++; $display("FAIL mid_idle: got %0d non-idle cycles want 0", not_idle); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_store_jz(16'h0000, 1'b1, 8'h05);
    test_store_jz(16'h0003, 1'b0, 8'h02);
    test_wait_states();
    test_halt_nop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_ctrl_fsm.md
Name: accum_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit accumulator datapath: 8-bit PC/MAR, 16-bit IR/ACC/MDR, 2-bit ALU op.
- Drives every datapath load/mux strobe, the ALU op and the memory write enable.
- Fetches, decodes and executes one instruction at a time. Instruction format: IR[15:8] = address, IR[7:0] = opcode.
- Supports memory read latency through a programmable wait-state counter.

Parameters:
- MEM_WAIT, 0: extra cycles between a MAR load and MemQ being valid; range 0–15.
- ALU_ADD, 2'b00: opALU code for add.
- ALU_SUB, 2'b01: opALU code for subtract.
- ALU_AND, 2'b10: opALU code for bitwise AND.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  level; leaves IDLE when 1.
- opcode  in  8  IR[7:0] from the datapath.
- Zflag  in  1  1 when ACC == 0.
- loadPC, loadIR, loadACC, loadMDR, loadMAR  out  1 each  datapath register load strobes.
- muxPC  out  1  1 selects IR[15:8], 0 selects PC+1.
- muxMAR  out  1  1 selects PC, 0 selects IR[15:8].
- muxACC  out  1  1 selects MDR, 0 selects ALU_out.
- opALU  out  2  ALU operation.
- MemWE  out  1  memory write: M[MemAddr] <= MemD (ACC).
- Halted  out  1  high while in HALT.
- InstrCnt  out  16  number of instructions decoded.

Behaviour:
- Opcodes:
  - 0x01 LOAD: ACC <= M[a]
  - 0x02 STORE: M[a] <= ACC
  - 0x03 ADD: ACC <= ACC + M[a]
  - 0x04 SUB: ACC <= ACC − M[a]
  - 0x05 AND: ACC <= ACC & M[a]
  - 0x06 JMP: PC <= a
  - 0x07 JZ: PC <= a if Zflag = 1
  - 0x08 HALT
  - Any other value executes as a NOP.
- Outputs are Moore-decoded from the state register, except the DECODE-cycle strobes, which also depend on opcode/Zflag. Strobes not listed for a state are 0; opALU defaults to ALU_ADD; mux outputs default to 0.
- Reset (Rst = 0 at an edge):
  - State becomes IDLE; wait counter and InstrCnt become 0.
  - All strobes, MemWE and Halted read 0 from the following cycle.
  - This applies in every state, including mid-instruction and during HALT.
- States and per-state actions:
  - IDLE: no strobes. Start = 1 -> F_ADDR.
  - F_ADDR: loadMAR = 1, muxMAR = 1. Next: F_WAIT if MEM_WAIT > 0, else F_MEM.
  - F_WAIT: counter loads MEM_WAIT−1 on entry and decrements each cycle; exits to F_MEM in the cycle the count is 0. Occupies exactly MEM_WAIT cycles.
  - F_MEM: loadMDR = 1; loadPC = 1 with muxPC = 0 (PC+1). Next: F_IR.
  - F_IR: loadIR = 1. Next: DECODE.
  - DECODE: InstrCnt += 1 (wraps at 16 bits). Then by opcode:
    - LOAD/ADD/SUB/AND/STORE -> E_ADDR.
    - JMP: loadPC = 1, muxPC = 1 -> F_ADDR.
    - JZ, Zflag = 1: loadPC = 1, muxPC = 1 -> F_ADDR.
    - JZ, Zflag = 0: no strobe -> F_ADDR.
    - HALT -> HALT.
    - NOP -> F_ADDR.
  - E_ADDR: loadMAR = 1, muxMAR = 0. STORE -> E_STORE. Others -> E_WAIT (if MEM_WAIT > 0) or E_MEM.
  - E_WAIT: same counting as F_WAIT, then -> E_MEM.
  - E_MEM: loadMDR = 1. Next: E_ACC.
  - E_ACC: loadACC = 1.
    - LOAD: muxACC = 1.
    - ADD/SUB/AND: muxACC = 0, opALU = the matching code.
    - opALU holds that code in E_MEM and E_ACC.
    - Next: F_ADDR.
  - E_STORE: MemWE = 1 for exactly one cycle; no wait states. Next: F_ADDR.
  - HALT: Halted = 1, no strobes. Only reset leaves HALT; Start is ignored.
- Opcode latching: opcode is sampled in DECODE and latched internally for the E_* states, so the IR contents need not stay valid after DECODE.
- Zflag is sampled only in the DECODE cycle.
- Latency with MEM_WAIT = W:
  - Fetch + decode: 4 + W cycles.
  - LOAD/ALU instructions: 7 + 2W cycles.
  - STORE: 6 + W cycles.
  - JMP/JZ/NOP: 4 + W cycles.
- Invariant: at most one of MemWE and loadMDR is high in any cycle.

Test Plan:
- Reset/idle: hold Rst = 0 for 3 cycles, then Rst = 1, Start = 0 -> all strobes 0, Halted = 0, InstrCnt = 0, FSM stays in IDLE. Assert Start -> loadMAR = 1, muxMAR = 1 in the next cycle.
- LOAD then ADD, MEM_WAIT = 0: M[0] = 0x1001, M[1] = 0x1103, M[0x10] = 5, M[0x11] = 7 -> ACC = 12 after 14 cycles. loadACC has muxACC = 1 on the first instruction and muxACC = 0, opALU = 00 on the second.
- STORE and JZ: M[0] = 0x2002 stores ACC = 0 to 0x20; M[1] = 0x0507 with Zflag = 1 -> MemWE is a single pulse with MemAddr = 0x20, and PC = 0x05 after JZ. Repeat with ACC = 3 -> no loadPC in DECODE, PC = 0x02.
- Wait states, MEM_WAIT = 3: a LOAD instruction -> exactly 3 idle cycles before each loadMDR; instruction length = 13 cycles.
- HALT and unknown opcode: M[0] = 0x00FF, M[1] = 0x0008 -> 0xFF executes as a NOP, then Halted = 1 and persists for 50 cycles with Start = 1; InstrCnt = 2.
- Reset mid-operation: drive Rst = 0 in E_MEM -> in the next cycle loadMDR, loadACC and all other strobes are 0 and the state is IDLE; no MemWE ever appears.
